dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 199 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory target answering load/store requests after WAIT_CYCLES wait states.
// Optional out-of-range detection is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return merged;
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [29:0] idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic          acc_en_s;
   logic          acc_write_s;
   logic [29:0]   acc_idx_s;
   logic [31:0]   acc_wdata_s;
   logic [3:0]    acc_be_s;
   logic [AW-1:0] mem_addr_s;
   logic [31:0]   mem_rd_s;
   logic [31:0]   mem_wdata_s;
   logic          mem_we_s;
   logic          in_range_s;
   logic          unused_s;

   logic [31:0] mem_q [DEPTH_WORDS];

   assign mem_addr_s = acc_idx_s[AW-1:0];
   assign mem_rd_s   = mem_q[mem_addr_s];

`ifdef DMEM_RANGE_CHECK_EN
   assign in_range_s = ((acc_idx_s >> AW) == 30'd0) ? 1'b1 : 1'b0;
`else
   assign in_range_s = 1'b1;
`endif

   // Next-state, request latching and access decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      acc_en_s    = 1'b0;
      acc_write_s = wr_q;
      acc_idx_s   = idx_q;
      acc_wdata_s = wdata_q;
      acc_be_s    = be_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               idx_d   = req_addr[31:2];
               wdata_d = req_wdata;
               be_d    = req_be;
               if (ZERO_WAIT) begin
                  // No wait states: access straight from the request inputs.
                  acc_en_s    = 1'b1;
                  acc_write_s = req_write;
                  acc_idx_s   = req_addr[31:2];
                  acc_wdata_s = req_wdata;
                  acc_be_s    = req_be;
                  cnt_d       = 4'd0;
                  state_d     = ST_RESP;
               end else begin
                  cnt_d   = WAIT_LOAD;
                  state_d = ST_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               acc_en_s = 1'b1;
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      if (acc_en_s) begin
         if (in_range_s) begin
            rdata_d = acc_write_s ? 32'd0 : mem_rd_s;
            err_d   = 1'b0;
         end else begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
         end
      end else begin
         rdata_d = rdata_q;
         err_d   = err_q;
      end
   end

   // Stores are held off while reset is asserted so an edge during reset never commits.
   assign mem_we_s    = reset & acc_en_s & acc_write_s & in_range_s;
   assign mem_wdata_s = merge_bytes(mem_rd_s, acc_wdata_s, acc_be_s);

   // Control and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         idx_q   <= 30'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage array; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_addr_s] <= mem_wdata_s;
      end
   end

   assign req_ready  = (state_q == ST_IDLE) ? 1'b1 : 1'b0;
   assign resp_valid = (state_q == ST_RESP) ? 1'b1 : 1'b0;
   assign resp_rdata = rdata_q;

`ifdef DMEM_RANGE_CHECK_EN
   assign resp_err = err_q;
   assign unused_s = ^{req_addr[1:0], acc_idx_s};
`else
   assign resp_err = 1'b0;
   assign unused_s = ^{req_addr[1:0], acc_idx_s, err_q};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Range expectations follow DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        z_req_valid, z_req_ready, z_req_write;
   logic [31:0] z_req_addr, z_req_wdata;
   logic [3:0]  z_req_be;
   logic        z_resp_valid, z_resp_ready;
   logic [31:0] z_resp_rdata;
   logic        z_resp_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
      .clk(clk), .reset(rst_n),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
      .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
      .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One transaction on the WAIT_CYCLES=2 instance; hold>0 stalls resp_ready in RESP.
   task automatic xact(input string tag, input logic w, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       input logic [31:0] exp_rdata, input logic exp_err);
      int lat;
      logic [31:0] held;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = addr;
      req_wdata  = wdata;
      req_be     = be;
      resp_ready = (hold == 0) ? 1'b1 : 1'b0;
      check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFC;
      req_wdata = 32'h0BAD_0BAD;
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'd3);
      check({tag, "_rdata"}, resp_rdata, exp_rdata);
      check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      check({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_bp_valid"}, {31'd0, resp_valid}, 32'd1);
         check({tag, "_bp_rdata"}, resp_rdata, held);
         check({tag, "_bp_ready"}, {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_done_rdata"}, resp_rdata, exp_rdata);
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = 32'd0;
      req_wdata   = 32'd0;
      req_be      = 4'd0;
      resp_ready  = 1'b1;
      z_req_valid = 1'b0;
      z_req_write = 1'b0;
      z_req_addr  = 32'd0;
      z_req_wdata = 32'd0;
      z_req_be    = 4'd0;
      z_resp_ready = 1'b1;
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", {31'd0, resp_err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      xact("st_full", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'd0, 1'b0);
      xact("ld_full", 1'b0, 32'h10, 32'd0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);

      xact("st_base", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, 32'd0, 1'b0);
      xact("st_part", 1'b1, 32'h23, 32'hAABB_CCDD, 4'b0101, 0, 32'd0, 1'b0);
      xact("ld_part", 1'b0, 32'h20, 32'd0, 4'h0, 0, 32'h11BB_33DD, 1'b0);
      xact("st_be0", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 32'd0, 1'b0);
      xact("ld_be0", 1'b0, 32'h20, 32'd0, 4'h0, 0, 32'h11BB_33DD, 1'b0);

      xact("ld_bp", 1'b0, 32'h10, 32'd0, 4'h0, 5, 32'hDEAD_BEEF, 1'b0);

      xact("st_w0", 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 0, 32'd0, 1'b0);
`ifdef DMEM_RANGE_CHECK_EN
      xact("st_oor", 1'b1, 32'h400, 32'hA5A5_A5A5, 4'hF, 0, 32'd0, 1'b1);
      xact("ld_w0", 1'b0, 32'h0, 32'd0, 4'h0, 0, 32'h0BAD_F00D, 1'b0);
      xact("ld_oor", 1'b0, 32'h404, 32'd0, 4'h0, 0, 32'd0, 1'b1);
`else
      xact("st_wrap", 1'b1, 32'h400, 32'hA5A5_A5A5, 4'hF, 0, 32'd0, 1'b0);
      xact("ld_w0", 1'b0, 32'h0, 32'd0, 4'h0, 0, 32'hA5A5_A5A5, 1'b0);
`endif

      // Reset while a store is waiting: store must be dropped.
      xact("st_prev", 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 0, 32'd0, 1'b0);
      xact("ld_prev", 1'b0, 32'h8, 32'd0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h8;
      req_wdata = 32'h1234_5678;
      req_be    = 4'hF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("mid_wait_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
      check("mid_rst_rdata", resp_rdata, 32'd0);
      check("mid_rst_err", {31'd0, resp_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      xact("ld_after_rst", 1'b0, 32'h8, 32'd0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);

      // Zero-wait instance: single-cycle latency, back-to-back every 2 cycles.
      @(negedge clk);
      z_req_valid = 1'b1;
      z_req_write = 1'b1;
      z_req_addr  = 32'h40;
      z_req_wdata = 32'h5A5A_0F0F;
      z_req_be    = 4'hF;
      @(posedge clk);
      #1;
      z_req_valid = 1'b0;
      check("z_st_valid", {31'd0, z_resp_valid}, 32'd1);
      check("z_st_busy", {31'd0, z_req_ready}, 32'd0);
      check("z_st_rdata", z_resp_rdata, 32'd0);
      @(posedge clk);
      #1;
      check("z_st_done", {31'd0, z_resp_valid}, 32'd0);
      z_req_valid = 1'b1;
      z_req_write = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("z_b2b_valid", {31'd0, z_resp_valid}, ((i % 2) == 0) ? 32'd1 : 32'd0);
         check("z_b2b_ready", {31'd0, z_req_ready}, ((i % 2) == 0) ? 32'd0 : 32'd1);
         if ((i % 2) == 0) begin
            check("z_b2b_rdata", z_resp_rdata, 32'h5A5A_0F0F);
         end
      end
      z_req_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
